// File: rtl/lab2_seg7_drv_if.sv
// Seven-segment driver signal bundle: upstream PIO inputs and display outputs.
interface lab2_seg7_drv_if;
    logic [3:0] value;
    logic       enable;
    logic [3:0] brightness;
    logic [6:0] hex_n;
    logic       dp_n;
    logic       changed;

    modport master (output value, enable, brightness, input  hex_n, dp_n, changed);
    modport slave  (input  value, enable, brightness, output hex_n, dp_n, changed);
endinterface

// File: rtl/lab2_seg7_drv.sv
// Hex digit to active-low 7-segment driver with change pulse and decimal-point flash.
// Optional SEG7_PWM_EN adds a 16-step brightness PWM; default build is always full-on.
module lab2_seg7_drv #(
    parameter int unsigned FLASH_CYCLES = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    lab2_seg7_drv_if.slave   bus
);
    localparam logic [25:0] FLASH_LD = 26'(FLASH_CYCLES);

    logic [3:0]  value_q,   value_d;
    logic [25:0] cnt_q,     cnt_d;
    logic [6:0]  hex_n_q,   hex_n_d;
    logic        dp_n_q,    dp_n_d;
    logic        changed_q, changed_d;
    logic        chg;
    logic        lit;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
        endcase
    endfunction

`ifdef SEG7_PWM_EN
    logic [3:0] p_q, p_d;

    always_comb begin
        p_d = p_q + 4'd1;
        lit = (bus.brightness == 4'hF) || (p_q < bus.brightness);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) p_q <= '0;
        else          p_q <= p_d;
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^bus.brightness;
    assign lit = 1'b1;
`endif

    always_comb begin
        value_d   = bus.value;
        chg       = (bus.value != value_q);
        changed_d = chg;
        // A change always reloads, so a flash restarts rather than stretching.
        if (chg)                cnt_d = FLASH_LD;
        else if (cnt_q != '0)   cnt_d = cnt_q - 26'd1;
        else                    cnt_d = cnt_q;
        hex_n_d = (bus.enable && lit) ? glyph(bus.value) : 7'h7F;
        // Driven from the next count so dp goes low on the same edge the count loads.
        dp_n_d  = !(bus.enable && lit && (cnt_d != '0));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q   <= '0;
            cnt_q     <= '0;
            hex_n_q   <= 7'h7F;
            dp_n_q    <= 1'b1;
            changed_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            cnt_q     <= cnt_d;
            hex_n_q   <= hex_n_d;
            dp_n_q    <= dp_n_d;
            changed_q <= changed_d;
        end
    end

    assign bus.hex_n   = hex_n_q;
    assign bus.dp_n    = dp_n_q;
    assign bus.changed = changed_q;
endmodule

// File: tb/tb_lab2_seg7_drv.sv
// Scoreboard bench for lab2_seg7_drv with FLASH_CYCLES=8 and hand-computed expectations.
module tb_lab2_seg7_drv;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    typedef struct packed {
        logic [6:0] hex;
        logic       dp;
        logic       chg;
    } exp_t;

    exp_t exp_q[$];

    lab2_seg7_drv_if bus ();

    lab2_seg7_drv #(.FLASH_CYCLES(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic step(input logic [3:0] v, input logic en,
                        input logic [6:0] hex, input logic dp, input logic chg);
        @(negedge clk);
        bus.value  = v;
        bus.enable = en;
        exp_q.push_back('{hex: hex, dp: dp, chg: chg});
    endtask

    task automatic steps(input int n, input logic [3:0] v, input logic en,
                         input logic [6:0] hex, input logic dp, input logic chg);
        for (int i = 0; i < n; i++) step(v, en, hex, dp, chg);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("hex_n",   {1'b0, bus.hex_n}, {1'b0, e.hex});
            check("dp_n",    {7'b0, bus.dp_n},  {7'b0, e.dp});
            check("changed", {7'b0, bus.changed}, {7'b0, e.chg});
        end
    end

    task automatic drain;
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 50) begin
            @(posedge clk); #2;
            budget++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", 8'(exp_q.size()), 8'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n        = 1'b0;
        bus.value      = 4'h0;
        bus.enable     = 1'b1;
        bus.brightness = 4'hF;
        #23;
        check("rst_hex",  {1'b0, bus.hex_n}, 8'h7F);
        check("rst_dp",   {7'b0, bus.dp_n},  8'h01);
        check("rst_chg",  {7'b0, bus.changed}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle at zero after reset: no pulse, no flash.
        steps(10, 4'h0, 1'b1, 7'h40, 1'b1, 1'b0);

        // 0 -> A: one pulse, dp low for exactly 8 cycles.
        step(4'hA, 1'b1, 7'h08, 1'b0, 1'b1);
        steps(7, 4'hA, 1'b1, 7'h08, 1'b0, 1'b0);
        steps(3, 4'hA, 1'b1, 7'h08, 1'b1, 1'b0);

        // 3 then 5 four cycles later: restart gives 12 low cycles, two pulses.
        step(4'h3, 1'b1, 7'h30, 1'b0, 1'b1);
        steps(3, 4'h3, 1'b1, 7'h30, 1'b0, 1'b0);
        step(4'h5, 1'b1, 7'h12, 1'b0, 1'b1);
        steps(7, 4'h5, 1'b1, 7'h12, 1'b0, 1'b0);
        steps(2, 4'h5, 1'b1, 7'h12, 1'b1, 1'b0);

        // Blanked change 7 -> E, re-enable three cycles later shows remaining 5 flash cycles.
        step(4'h7, 1'b1, 7'h78, 1'b0, 1'b1);
        steps(7, 4'h7, 1'b1, 7'h78, 1'b0, 1'b0);
        step(4'h7, 1'b1, 7'h78, 1'b1, 1'b0);
        step(4'hE, 1'b0, 7'h7F, 1'b1, 1'b1);
        steps(2, 4'hE, 1'b0, 7'h7F, 1'b1, 1'b0);
        steps(5, 4'hE, 1'b1, 7'h06, 1'b0, 1'b0);
        steps(2, 4'hE, 1'b1, 7'h06, 1'b1, 1'b0);

        // Blank and unblank with no flash pending.
        step(4'hE, 1'b0, 7'h7F, 1'b1, 1'b0);
        step(4'hE, 1'b1, 7'h06, 1'b1, 1'b0);

        // Asynchronous reset mid-flash.
        step(4'h1, 1'b1, 7'h79, 1'b0, 1'b1);
        steps(2, 4'h1, 1'b1, 7'h79, 1'b0, 1'b0);
        drain();
        reset_n = 1'b0;
        #1;
        check("async_hex", {1'b0, bus.hex_n}, 8'h7F);
        check("async_dp",  {7'b0, bus.dp_n},  8'h01);
        check("async_chg", {7'b0, bus.changed}, 8'h00);
        @(negedge clk);
        bus.value = 4'h0;
        @(negedge clk);
        reset_n = 1'b1;
        steps(3, 4'h0, 1'b1, 7'h40, 1'b1, 1'b0);

        // Release with a nonzero value: first edge sees a change.
        drain();
        @(negedge clk);
        reset_n   = 1'b0;
        bus.value = 4'hF;
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back('{hex: 7'h0E, dp: 1'b0, chg: 1'b1});
        steps(2, 4'hF, 1'b1, 7'h0E, 1'b0, 1'b0);

`ifdef SEG7_PWM_EN
        drain();
        begin
            int on_cnt;
            bus.value      = 4'h8;
            bus.brightness = 4'h4;
            repeat (12) @(negedge clk);
            on_cnt = 0;
            repeat (32) begin
                @(posedge clk); #1;
                if (bus.hex_n == 7'h00) on_cnt++;
            end
            check("pwm_b4_on", 8'(on_cnt), 8'd8);
            bus.brightness = 4'hF;
            @(negedge clk);
            on_cnt = 0;
            repeat (16) begin
                @(posedge clk); #1;
                if (bus.hex_n == 7'h00) on_cnt++;
            end
            check("pwm_b15_on", 8'(on_cnt), 8'd16);
            bus.brightness = 4'h0;
            @(negedge clk);
            on_cnt = 0;
            repeat (16) begin
                @(posedge clk); #1;
                if (bus.hex_n == 7'h7F) on_cnt++;
            end
            check("pwm_b0_off", 8'(on_cnt), 8'd16);
        end
`else
        // Brightness has no effect without the PWM option.
        @(negedge clk);
        bus.brightness = 4'h0;
        step(4'h8, 1'b1, 7'h00, 1'b0, 1'b1);
        steps(3, 4'h8, 1'b1, 7'h00, 1'b0, 1'b0);
`endif

        drain();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/lab2_seg7_drv.md
LAB2_SEG7_DRV -- requirements
Module: lab2_seg7_drv

Interface
- REQ-001: Parameter FLASH_CYCLES, default 25000000, sets the number of clk cycles the decimal point stays lit after a value change (0.5 s at 50 MHz); legal range 1 to 2^26-1.
- REQ-002: clk  input  1  system clock; all state SHALL be updated on the rising edge.
- REQ-003: reset_n  input  1  asynchronous, active-low reset.
- REQ-004: value  input  4  hex digit from the upstream 4-bit PIO out_port; level signal, no strobe.
- REQ-005: enable  input  1  1 = display driven; 0 = display blanked.
- REQ-006: brightness  input  4  duty level 0..15; used only with SEG7_PWM_EN.
- REQ-007: hex_n  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- REQ-008: dp_n  output  1  decimal point, active-low, registered.
- REQ-009: changed  output  1  one-cycle pulse on a detected value change, registered.

Function
- REQ-010: value_q SHALL capture value on every rising edge.
- REQ-011: A change SHALL be detected at an edge where value != value_q.
- REQ-012: changed SHALL be 1 for exactly the cycle following that edge; a value held constant SHALL produce no further pulses.
- REQ-013: hex_n SHALL show the standard hex glyph of value one edge after value is applied; latency 1 clk.
- REQ-014: Glyphs 0..F in hex_n bit order {g..a}: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- REQ-015: Flash counter behaviour: on each detected change, a 26-bit down-counter SHALL load FLASH_CYCLES and decrement once per cycle to 0.
- REQ-016: dp_n SHALL be 0 exactly while the counter is nonzero, giving exactly FLASH_CYCLES cycles low starting the cycle after the change edge.
- REQ-017: A change while the counter is nonzero SHALL reload it to FLASH_CYCLES (restart, not extend).
- REQ-018: The counter SHALL saturate at 0 and never wrap.
- REQ-019: enable=0 SHALL force hex_n=7F and dp_n=1 from the next edge.
- REQ-020: With enable=0, capture, change detection, changed pulses and the flash counter SHALL keep running.
- REQ-021: Re-enabling SHALL show the current glyph and any remaining flash from the next edge.
- REQ-022: A value change and an enable change on the same edge SHALL both take effect on that edge.

Reset
- REQ-023: While reset_n=0, the block SHALL asynchronously hold value_q=0, flash counter=0, PWM counter=0, hex_n=7F, dp_n=1, changed=0.
- REQ-024: The first edge after release SHALL compare value against value_q=0: value=0 gives no pulse; value!=0 gives changed and a flash.
- REQ-025: Reset asserted mid-flash SHALL clear the flash immediately, with no resumption after release.

Configuration
- REQ-026: Macro SEG7_PWM_EN, when defined, SHALL add a free-running 4-bit PWM counter p (0..15, wraps 15->0).
- REQ-027: With SEG7_PWM_EN, lit segments and dp SHALL be driven only when p < brightness, except brightness=15, which SHALL mean always lit.
- REQ-028: With SEG7_PWM_EN, brightness=0 SHALL mean always dark.
- REQ-029: Without SEG7_PWM_EN, brightness SHALL be ignored, no PWM counter SHALL be built, and outputs SHALL equal the full-on case.

Verification
- REQ-030: Reset with value=0, release, hold 10 cycles -> hex_n=40, changed never 1, dp_n stays 1.
- REQ-031: FLASH_CYCLES=8; step value 0->A at edge N -> hex_n=08 and changed=1 for the cycle after edge N only; dp_n=0 for exactly 8 cycles.
- REQ-032: FLASH_CYCLES=8; value 3, then 5 four cycles later -> flash restarts, dp_n low for 4+8=12 consecutive cycles, two changed pulses.
- REQ-033: enable=0 while value 7->E -> hex_n=7F and dp_n=1 throughout, changed pulses once; enable=1 three cycles later -> hex_n=06, dp_n=0 for the remaining FLASH_CYCLES-3 cycles.
- REQ-034: Assert reset_n=0 mid-flash between edges -> hex_n=7F, dp_n=1, changed=0 immediately, without waiting for a clock edge.
- REQ-035: SEG7_PWM_EN defined, brightness=4, value=8 -> hex_n=00 for 4 of every 16 cycles and 7F for 12; brightness=15 -> 00 continuously; brightness=0 -> 7F continuously.
